// File: rtl/piradip_axis_sample_buffer_writer.sv
// AXI4-Stream sample capture into a buffer write port, with one-shot or continuous wrap between two offsets.
// Latency: one cycle from accepted beat to mem_we. Backpressure: none, tready is high whenever out of reset and idle beats are dropped.
// Optional I/Q lane masking is compiled in by defining PIRADIP_SAMPLE_BUFFER_IQ_MASK_EN.
module piradip_axis_sample_buffer_writer #(
    parameter int STREAM_DATA_WIDTH   = 128,
    parameter int STREAM_OFFSET_WIDTH = 12
) (
    input  logic                           stream_clk,
    input  logic                           stream_rst,
    input  logic                           stream_update,
    input  logic                           stream_active,
    input  logic                           stream_one_shot,
    input  logic [STREAM_OFFSET_WIDTH-1:0] stream_start_offset,
    input  logic [STREAM_OFFSET_WIDTH-1:0] stream_end_offset,
    input  logic                           i_en,
    input  logic                           q_en,
    input  logic [STREAM_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    output logic                           mem_we,
    output logic [STREAM_OFFSET_WIDTH-1:0] mem_addr,
    output logic [STREAM_DATA_WIDTH-1:0]   mem_wdata,
    output logic                           stream_stopped,
    output logic                           stream_wrap_toggle
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                         state;
    logic [STREAM_OFFSET_WIDTH-1:0] sh_start;
    logic [STREAM_OFFSET_WIDTH-1:0] sh_end;
    logic                           sh_one_shot;
    logic [STREAM_OFFSET_WIDTH-1:0] addr;
    logic [STREAM_OFFSET_WIDTH-1:0] eff_end;
    logic [STREAM_DATA_WIDTH-1:0]   masked;
    logic                           beat;
    logic                           restart;
    logic                           at_end;

`ifdef PIRADIP_SAMPLE_BUFFER_IQ_MASK_EN
    // Even 16-bit lanes carry I samples, odd lanes carry Q samples.
    always_comb begin
        masked = s_axis_tdata;
        for (int l = 0; l < STREAM_DATA_WIDTH / 16; l++) begin
            if (((l % 2) == 0 && !i_en) || ((l % 2) == 1 && !q_en)) begin
                masked[l*16 +: 16] = 16'h0000;
            end
        end
    end
`else
    logic unused_lane_en;
    assign unused_lane_en = i_en ^ q_en;
    assign masked         = s_axis_tdata;
`endif

    assign s_axis_tready  = ~stream_rst;
    assign beat           = s_axis_tvalid & s_axis_tready;
    assign restart        = stream_update & stream_active;
    // A reversed window collapses to a single word at the start offset.
    assign eff_end        = (sh_start <= sh_end) ? sh_end : sh_start;
    assign at_end         = (addr == eff_end);
    assign stream_stopped = (state == IDLE);

    always_ff @(posedge stream_clk or posedge stream_rst) begin
        if (stream_rst) begin
            state              <= IDLE;
            sh_start           <= '0;
            sh_end             <= '1;
            sh_one_shot        <= 1'b0;
            addr               <= '0;
            mem_we             <= 1'b0;
            mem_addr           <= '0;
            mem_wdata          <= '0;
            stream_wrap_toggle <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (stream_update) begin
                sh_one_shot <= stream_one_shot;
                sh_start    <= stream_start_offset;
                sh_end      <= stream_end_offset;
            end
            if (state == IDLE) begin
                if (restart) begin
                    state <= RUN;
                    addr  <= stream_start_offset;
                end
            end else begin
                if (beat) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= addr;
                    mem_wdata <= masked;
                end
                // A restart wins over a wrap landing on the same beat; that beat still writes.
                if (restart) begin
                    addr <= stream_start_offset;
                end else if (beat && at_end) begin
                    addr               <= sh_start;
                    stream_wrap_toggle <= ~stream_wrap_toggle;
                    if (sh_one_shot) begin
                        state <= IDLE;
                    end
                end else if (beat) begin
                    addr <= addr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_piradip_axis_sample_buffer_writer.sv
// Self-checking bench for piradip_axis_sample_buffer_writer: directed scenarios plus a randomized pass model.
module tb_piradip_axis_sample_buffer_writer;
    localparam int DW = 128;
    localparam int AW = 12;

    logic          stream_clk = 1'b0;
    logic          stream_rst = 1'b0;
    logic          stream_update = 1'b0;
    logic          stream_active = 1'b0;
    logic          stream_one_shot = 1'b0;
    logic [AW-1:0] stream_start_offset = '0;
    logic [AW-1:0] stream_end_offset = '0;
    logic          i_en = 1'b1;
    logic          q_en = 1'b1;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          stream_stopped;
    logic          stream_wrap_toggle;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic exp_tog = 1'b0;

    piradip_axis_sample_buffer_writer #(
        .STREAM_DATA_WIDTH  (DW),
        .STREAM_OFFSET_WIDTH(AW)
    ) dut (
        .stream_clk         (stream_clk),
        .stream_rst         (stream_rst),
        .stream_update      (stream_update),
        .stream_active      (stream_active),
        .stream_one_shot    (stream_one_shot),
        .stream_start_offset(stream_start_offset),
        .stream_end_offset  (stream_end_offset),
        .i_en               (i_en),
        .q_en               (q_en),
        .s_axis_tdata       (s_axis_tdata),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tready      (s_axis_tready),
        .mem_we             (mem_we),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .stream_stopped     (stream_stopped),
        .stream_wrap_toggle (stream_wrap_toggle)
    );

    always #5 stream_clk = ~stream_clk;

    // Apply one cycle of inputs, then return just after the edge that consumed them.
    task automatic drive(input logic upd, input logic act, input logic os,
                         input logic [AW-1:0] st, input logic [AW-1:0] en,
                         input logic vld, input logic [DW-1:0] d);
        stream_update       = upd;
        stream_active       = act;
        stream_one_shot     = os;
        stream_start_offset = st;
        stream_end_offset   = en;
        s_axis_tvalid       = vld;
        s_axis_tdata        = d;
        @(posedge stream_clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [DW-1:0] exp_data(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = d;
`ifdef PIRADIP_SAMPLE_BUFFER_IQ_MASK_EN
        for (int l = 0; l < DW / 16; l++) begin
            if (((l % 2) == 0 && !i_en) || ((l % 2) == 1 && !q_en)) r[l*16 +: 16] = 16'h0000;
        end
`endif
        return r;
    endfunction

    task automatic test_reset();
        #2 stream_rst = 1'b1;
        #3;
        n_cmp++;
        if (mem_we !== 1'b0 || mem_addr !== 12'd0 || mem_wdata !== '0) begin
            n_bad++; $display("FAIL reset_write_port: we=%b addr=%0d wdata=%h, want 0/0/0", mem_we, mem_addr, mem_wdata);
        end
        n_cmp++;
        if (stream_stopped !== 1'b1 || stream_wrap_toggle !== 1'b0 || s_axis_tready !== 1'b0) begin
            n_bad++; $display("FAIL reset_status: stopped=%b toggle=%b tready=%b, want 1/0/0", stream_stopped, stream_wrap_toggle, s_axis_tready);
        end
        @(negedge stream_clk);
        stream_rst = 1'b0;
        exp_tog    = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b1, rand_data());
        n_cmp++;
        if (s_axis_tready !== 1'b1 || mem_we !== 1'b0 || stream_stopped !== 1'b1) begin
            n_bad++; $display("FAIL idle_after_reset: tready=%b we=%b stopped=%b, want 1/0/1", s_axis_tready, mem_we, stream_stopped);
        end
    endtask

    task automatic test_one_shot();
        logic [DW-1:0] d;
        drive(1'b1, 1'b1, 1'b1, 12'd4, 12'd7, 1'b0, '0);
        n_cmp++;
        if (stream_stopped !== 1'b0) begin
            n_bad++; $display("FAIL one_shot_start: stopped=%b, want 0", stream_stopped);
        end
        for (int k = 0; k < 6; k++) begin
            d = rand_data();
            drive(1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b1, d);
            n_cmp++;
            if (k < 4) begin
                if (mem_we !== 1'b1 || mem_addr !== AW'(4 + k) || mem_wdata !== exp_data(d)) begin
                    n_bad++; $display("FAIL one_shot_write%0d: we=%b addr=%0d, want 1 addr=%0d", k, mem_we, mem_addr, 4 + k);
                end
                if (k == 3) exp_tog = ~exp_tog;
            end else if (mem_we !== 1'b0) begin
                n_bad++; $display("FAIL one_shot_drop%0d: we=%b, want 0", k, mem_we);
            end
            n_cmp++;
            if (stream_wrap_toggle !== exp_tog) begin
                n_bad++; $display("FAIL one_shot_toggle%0d: got %b want %b", k, stream_wrap_toggle, exp_tog);
            end
        end
        n_cmp++;
        if (stream_stopped !== 1'b1) begin
            n_bad++; $display("FAIL one_shot_stopped: got %b want 1", stream_stopped);
        end
    endtask

    task automatic test_continuous();
        logic [DW-1:0] d;
        drive(1'b1, 1'b1, 1'b0, 12'd0, 12'd3, 1'b0, '0);
        for (int k = 0; k < 10; k++) begin
            d = rand_data();
            drive(1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b1, d);
            if (k % 4 == 3) exp_tog = ~exp_tog;
            n_cmp++;
            if (mem_we !== 1'b1 || mem_addr !== AW'(k % 4) || mem_wdata !== exp_data(d) || stream_wrap_toggle !== exp_tog) begin
                n_bad++; $display("FAIL continuous_beat%0d: we=%b addr=%0d tog=%b, want 1 addr=%0d tog=%b",
                                  k, mem_we, mem_addr, stream_wrap_toggle, k % 4, exp_tog);
            end
        end
        n_cmp++;
        if (stream_stopped !== 1'b0) begin
            n_bad++; $display("FAIL continuous_stopped: got %b want 0", stream_stopped);
        end
    endtask

    task automatic test_reversed_window();
        logic [DW-1:0] d;
        drive(1'b1, 1'b1, 1'b0, 12'd9, 12'd2, 1'b0, '0);
        for (int k = 0; k < 3; k++) begin
            d = rand_data();
            drive(1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b1, d);
            exp_tog = ~exp_tog;
            n_cmp++;
            if (mem_we !== 1'b1 || mem_addr !== 12'd9 || stream_wrap_toggle !== exp_tog) begin
                n_bad++; $display("FAIL reversed_beat%0d: we=%b addr=%0d tog=%b, want 1 addr=9 tog=%b",
                                  k, mem_we, mem_addr, stream_wrap_toggle, exp_tog);
            end
        end
    endtask

    task automatic test_restart_at_end();
        logic [DW-1:0] d;
        drive(1'b1, 1'b1, 1'b0, 12'd4, 12'd7, 1'b0, '0);
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b1, rand_data());
        d = rand_data();
        drive(1'b1, 1'b1, 1'b0, 12'd20, 12'd25, 1'b1, d);
        n_cmp++;
        if (mem_we !== 1'b1 || mem_addr !== 12'd7 || mem_wdata !== exp_data(d) || stream_wrap_toggle !== exp_tog) begin
            n_bad++; $display("FAIL restart_end_write: we=%b addr=%0d tog=%b, want 1 addr=7 tog=%b",
                              mem_we, mem_addr, stream_wrap_toggle, exp_tog);
        end
        drive(1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b1, rand_data());
        n_cmp++;
        if (mem_we !== 1'b1 || mem_addr !== 12'd20 || stream_stopped !== 1'b0) begin
            n_bad++; $display("FAIL restart_next_write: we=%b addr=%0d stopped=%b, want 1 addr=20 stopped=0",
                              mem_we, mem_addr, stream_stopped);
        end
    endtask

    task automatic test_reset_mid_pass();
        drive(1'b1, 1'b1, 1'b0, 12'd0, 12'd15, 1'b0, '0);
        for (int k = 0; k < 5; k++) drive(1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b1, rand_data());
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = rand_data();
        #2 stream_rst = 1'b1;
        #1;
        n_cmp++;
        if (mem_we !== 1'b0 || stream_stopped !== 1'b1 || stream_wrap_toggle !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid_pass: we=%b stopped=%b tog=%b, want 0/1/0", mem_we, stream_stopped, stream_wrap_toggle);
        end
        @(posedge stream_clk);
        #1;
        n_cmp++;
        if (mem_we !== 1'b0) begin
            n_bad++; $display("FAIL reset_inflight: we=%b, want 0", mem_we);
        end
        @(negedge stream_clk);
        stream_rst = 1'b0;
        exp_tog    = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b1, rand_data());
            n_cmp++;
            if (mem_we !== 1'b0 || stream_stopped !== 1'b1) begin
                n_bad++; $display("FAIL post_reset_idle%0d: we=%b stopped=%b, want 0/1", k, mem_we, stream_stopped);
            end
        end
    endtask

    task automatic test_iq_mask();
        logic [DW-1:0] want;
`ifdef PIRADIP_SAMPLE_BUFFER_IQ_MASK_EN
        want = 128'hFFFF0000FFFF0000FFFF0000FFFF0000;
`else
        want = '1;
`endif
        i_en = 1'b0;
        q_en = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 12'd0, 12'd0, 1'b0, '0);
        drive(1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b1, '1);
        exp_tog = ~exp_tog;
        n_cmp++;
        if (mem_we !== 1'b1 || mem_wdata !== want) begin
            n_bad++; $display("FAIL iq_mask: we=%b wdata=%h, want 1 wdata=%h", mem_we, mem_wdata, want);
        end
        i_en = 1'b1;
    endtask

    // Reference: the n-th accepted beat of a pass lands at start + (n mod window length).
    task automatic test_random();
        logic [AW-1:0] st, en;
        logic          os, vld, live;
        logic [DW-1:0] d;
        int            len, k, pos;
        for (int it = 0; it < 20; it++) begin
            st   = AW'($urandom_range(0, 15));
            en   = AW'($urandom_range(0, 15));
            os   = 1'($urandom_range(0, 1));
            i_en = 1'($urandom_range(0, 1));
            q_en = 1'($urandom_range(0, 1));
            len  = (st <= en) ? int'(en) - int'(st) + 1 : 1;
            k    = 0;
            live = 1'b1;
            drive(1'b1, 1'b1, os, st, en, 1'b0, '0);
            n_cmp++;
            if (mem_we !== 1'b0) begin
                n_bad++; $display("FAIL rand%0d_update: we=%b, want 0", it, mem_we);
            end
            for (int c = 0; c < 24; c++) begin
                vld = ($urandom_range(0, 3) != 0);
                d   = rand_data();
                drive(1'b0, 1'b0, 1'b0, 12'd0, 12'd0, vld, d);
                n_cmp++;
                if (vld && live) begin
                    pos = k % len;
                    if (mem_we !== 1'b1 || mem_addr !== AW'(int'(st) + pos) || mem_wdata !== exp_data(d)) begin
                        n_bad++; $display("FAIL rand%0d_write%0d: we=%b addr=%0d, want 1 addr=%0d",
                                          it, c, mem_we, mem_addr, int'(st) + pos);
                    end
                    if (pos == len - 1) begin
                        exp_tog = ~exp_tog;
                        if (os) live = 1'b0;
                    end
                    k++;
                end else if (mem_we !== 1'b0) begin
                    n_bad++; $display("FAIL rand%0d_nowrite%0d: we=%b, want 0", it, c, mem_we);
                end
                n_cmp++;
                if (stream_wrap_toggle !== exp_tog) begin
                    n_bad++; $display("FAIL rand%0d_toggle%0d: got %b want %b", it, c, stream_wrap_toggle, exp_tog);
                end
            end
            n_cmp++;
            if (stream_stopped !== !live) begin
                n_bad++; $display("FAIL rand%0d_stopped: got %b want %b", it, stream_stopped, !live);
            end
        end
        i_en = 1'b1;
        q_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_continuous();
        test_reversed_window();
        test_restart_at_end();
        test_reset_mid_pass();
        test_iq_mask();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/piradip_axis_sample_buffer_writer.md
PIRADIP_AXIS_SAMPLE_BUFFER_WRITER -- requirements
Module: piradip_axis_sample_buffer_writer

Interface
REQ-001 SHALL have parameter STREAM_DATA_WIDTH, default 128: AXIS beat width in bits, a multiple of 32.
REQ-002 SHALL have parameter STREAM_OFFSET_WIDTH, default 12: buffer word-address width.
REQ-003 SHALL have port stream_clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port stream_rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port stream_update, input, 1: single-cycle strobe marking a new control word.
REQ-006 SHALL have port stream_active, input, 1: start request; valid only when stream_update=1.
REQ-007 SHALL have port stream_one_shot, input, 1: one-shot mode; valid only when stream_update=1.
REQ-008 SHALL have port stream_start_offset, input, STREAM_OFFSET_WIDTH: first buffer word of a pass; valid only when stream_update=1.
REQ-009 SHALL have port stream_end_offset, input, STREAM_OFFSET_WIDTH: last buffer word of a pass; valid only when stream_update=1.
REQ-010 SHALL have ports i_en and q_en, inputs, 1 each: lane enables, level signals.
REQ-011 SHALL have ports s_axis_tdata (STREAM_DATA_WIDTH), s_axis_tvalid (1), inputs, and s_axis_tready (1), output: AXI4-Stream sample input.
REQ-012 SHALL have ports mem_we (1), mem_addr (STREAM_OFFSET_WIDTH) and mem_wdata (STREAM_DATA_WIDTH), outputs: buffer write port.
REQ-013 SHALL have ports stream_stopped (1) and stream_wrap_toggle (1), outputs: status returned toward the CSR block.

Function
REQ-014 SHALL capture stream_one_shot, stream_start_offset and stream_end_offset into shadow registers on every cycle with stream_update=1.
REQ-015 SHALL define effective_end as end if start<=end, else start; start>end yields a single-word pass.
REQ-016 SHALL implement an FSM with states IDLE and RUN; stream_stopped=1 exactly in IDLE.
REQ-017 SHALL transition IDLE->RUN, with next write address = new start_offset, on stream_update=1 && stream_active=1.
REQ-018 SHALL, in RUN, on a stream_update=1 && stream_active=1, restart the pass with next address = new start_offset.
REQ-019 SHALL, on stream_update with stream_active=0, update the shadows only; a running capture continues and new offsets take effect at the next wrap.
REQ-020 SHALL treat a beat (tvalid=1 && tready=1) in RUN as a write: next cycle mem_we=1, mem_addr=current address, mem_wdata=masked tdata (1-cycle latency, registered outputs).
REQ-021 SHALL, on a write at address==effective_end, reload address from the shadow start and invert stream_wrap_toggle in the same cycle as the mem_we for that beat.
REQ-022 SHALL, at that wrap, enter IDLE if shadow one_shot=1, else remain in RUN.
REQ-023 SHALL otherwise increment the address by 1 per beat, modulo 2^STREAM_OFFSET_WIDTH.
REQ-024 SHALL hold s_axis_tready=1 whenever stream_rst=0; beats in IDLE are discarded with mem_we=0.
REQ-025 SHALL, for a restart coinciding with the beat at effective_end, write that beat at effective_end, suppress the toggle, and give restart priority (next address = new start, state RUN).
REQ-026 SHALL keep mem_we=0 in any cycle with no preceding beat.

Reset
REQ-027 SHALL, on stream_rst=1, immediately force state IDLE, mem_we=0, mem_addr=0, mem_wdata=0, stream_stopped=1, stream_wrap_toggle=0, s_axis_tready=0, and shadows to start=0, end=all-ones, one_shot=0.
REQ-028 SHALL abandon a capture when reset is asserted mid-pass; no write issues for the in-flight beat.

Configuration
REQ-029 SHALL, with macro PIRADIP_SAMPLE_BUFFER_IQ_MASK_EN defined, treat tdata as 16-bit lanes (even lanes I, odd lanes Q) and zero I lanes when i_en=0 and Q lanes when q_en=0, combinationally before the write register.
REQ-030 SHALL, without the macro, ignore i_en/q_en and write tdata unmodified.

Verification
REQ-031 Bench SHALL cover: update active=1, start=4, end=7, one_shot=1, 6 continuous beats -> writes at 4,5,6,7, toggle flips once, stopped=1 after, beats 5-6 dropped.
REQ-032 Bench SHALL cover: continuous, start=0, end=3, 10 beats -> addresses 0,1,2,3,0,1,2,3,0,1, two toggle inversions, stopped=0.
REQ-033 Bench SHALL cover: start=9, end=2, one_shot=0, 3 beats -> all writes at address 9, toggle inverts on each beat.
REQ-034 Bench SHALL cover: restart (start=20) on the cycle of the beat at end=7 -> that write at 7, no toggle, next write at 20.
REQ-035 Bench SHALL cover: stream_rst pulsed mid-pass at address 5 -> mem_we=0 and stopped=1 at once, toggle=0, no writes until next active update.
REQ-036 Bench SHALL cover: macro defined, i_en=0, q_en=1, tdata all 0xFFFF lanes -> mem_wdata even lanes 0x0000, odd lanes 0xFFFF; macro undefined -> all 0xFFFF.
